// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// The watchdog feature is controlled by the RUN_SEQ_TIMEOUT_EN macro in run_sequencer.
package run_seq_pkg;

  typedef enum logic [2:0] {IDLE, RST, START, RUN, LOG, DONE} run_state_t;

  localparam int CW_DEF             = 16;
  localparam int RST_CYCLES_DEF     = 4;
  localparam int START_CYCLES_DEF   = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load of N-1 therefore gives a phase of exactly N cycles ending on tc.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge Clk) begin
    if (Reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/run_sequencer.sv
// Start/Ack program launcher: resets the core once per run, then launches programs
// 0..NumProgs-1 and logs each execution cycle count. Optional watchdog: RUN_SEQ_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for Go after reset
//   RST   | core reset held for RST_CYCLES
//   START | Start pulse held for START_CYCLES, cycle counter cleared
//   RUN   | counting cycles until Ack (or watchdog)
//   LOG   | one-cycle result strobe, then next program or DONE
//   DONE  | run complete, waiting for Go
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int CW             = CW_DEF,
  parameter int RST_CYCLES     = RST_CYCLES_DEF,
  parameter int START_CYCLES   = START_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic [1:0]    NumProgs,
  output logic          DutReset,
  output logic          DutStart,
  input  logic          DutAck,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] LastCycles,
  output logic          LogValid,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut
);

  // Timer is sized for the longest phase it may be loaded with.
  localparam int TW = $clog2(max3(RST_CYCLES, START_CYCLES, TIMEOUT_CYCLES) + 1);

  run_state_t    state, state_next;
  logic          tmr_load, tmr_tc, timeout_hit;
  logic [TW-1:0] tmr_val;
  logic [CW-1:0] cyc_cnt, cnt_inc;
  logic [1:0]    num_progs_q;
  logic          go_accept;

  phase_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign cnt_inc   = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
  assign go_accept = ((state == IDLE) || (state == DONE)) && Go;

  always_comb begin
    state_next  = state;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE, DONE: if (Go) begin
        state_next = RST;
        tmr_load   = 1'b1;
        tmr_val    = TW'(RST_CYCLES - 1);
      end
      RST: if (tmr_tc) begin
        if (num_progs_q == 2'd0) state_next = DONE;
        else begin
          state_next = START;
          tmr_load   = 1'b1;
          tmr_val    = TW'(START_CYCLES - 1);
        end
      end
      START: if (tmr_tc) begin
        state_next = RUN;
`ifdef RUN_SEQ_TIMEOUT_EN
        tmr_load   = 1'b1;
        tmr_val    = TW'(TIMEOUT_CYCLES - 1);
`endif
      end
      RUN: begin
        if (DutAck) state_next = LOG;
`ifdef RUN_SEQ_TIMEOUT_EN
        else if (tmr_tc) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
`endif
      end
      LOG: begin
        if (ProgIdx == num_progs_q - 2'd1) state_next = DONE;
        else begin
          state_next = START;
          tmr_load   = 1'b1;
          tmr_val    = TW'(START_CYCLES - 1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      DutReset    <= 1'b0;
      DutStart    <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      LogValid    <= 1'b0;
      ProgIdx     <= '0;
      LastCycles  <= '0;
      cyc_cnt     <= '0;
      num_progs_q <= '0;
    end else begin
      state    <= state_next;
      DutReset <= (state_next == RST);
      DutStart <= (state_next == START);
      Busy     <= (state_next != IDLE) && (state_next != DONE);
      Done     <= (state_next == DONE);
      LogValid <= (state_next == LOG) || timeout_hit;
      if (go_accept) begin
        num_progs_q <= NumProgs;
        ProgIdx     <= '0;
      end
      if (state_next == START && state != START) cyc_cnt <= '0;
      else if (state == RUN)                     cyc_cnt <= cnt_inc;
      if (state == RUN && state_next == LOG) LastCycles <= cnt_inc;
      if (state == LOG && state_next == START) ProgIdx <= ProgIdx + 2'd1;
`ifdef RUN_SEQ_TIMEOUT_EN
      if (timeout_hit) LastCycles <= CW'(TIMEOUT_CYCLES);
`endif
    end
  end

`ifdef RUN_SEQ_TIMEOUT_EN
  logic timed_out;
  always_ff @(posedge Clk) begin
    if (Reset || go_accept) timed_out <= 1'b0;
    else if (timeout_hit)   timed_out <= 1'b1;
  end
  assign TimedOut = timed_out;
`else
  assign TimedOut = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized self-checking bench for run_sequencer with a behavioural processor/Ack model.
// Watchdog scenario is exercised only when RUN_SEQ_TIMEOUT_EN is defined.
module tb_run_sequencer;

  localparam int CW  = 16;
  localparam int RSC = 4;
  localparam int SC  = 2;
  localparam int TMO = 20;

  logic          Clk = 1'b0;
  logic          Reset, Go, DutAck;
  logic [1:0]    NumProgs;
  logic          DutReset, DutStart, LogValid, Busy, Done, TimedOut;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] LastCycles;

  run_sequencer #(.CW(CW), .RST_CYCLES(RSC), .START_CYCLES(SC), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs), .DutReset(DutReset),
    .DutStart(DutStart), .DutAck(DutAck), .ProgIdx(ProgIdx), .LastCycles(LastCycles),
    .LogValid(LogValid), .Busy(Busy), .Done(Done), .TimedOut(TimedOut)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int rst_hi, start_hi, first_rst, first_start;
  int log_idx[$], log_cyc[$];
  int dly[4];
  bit hold_ack, started, running;
  int rc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs #1 after the edge, then let the processor model react.
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (DutReset) begin
      rst_hi++;
      if (first_rst < 0) first_rst = cyc;
    end
    if (DutStart) begin
      start_hi++;
      if (first_start < 0) first_start = cyc;
    end
    if (LogValid) begin
      log_idx.push_back(int'(ProgIdx));
      log_cyc.push_back(int'(LastCycles));
    end
    if (Reset) begin
      started = 0; running = 0; DutAck = 1'b0;
    end else if (hold_ack) begin
      DutAck = 1'b1;
    end else begin
      if (DutStart) begin
        started = 1; DutAck = 1'b0;
      end else if (started) begin
        started = 0; running = 1; rc = 0;
      end
      if (running) begin
        rc++;
        if (rc == dly[ProgIdx]) begin
          DutAck = 1'b1; running = 0;
        end
      end
    end
  endtask

  task automatic clear_obs();
    rst_hi = 0; start_hi = 0; first_rst = -1; first_start = -1;
    log_idx.delete(); log_cyc.delete();
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000 && !Done; k++) tick();
    check({tag, "_done"}, Done, 1);
  endtask

  // One full run; expectations come straight from the launch rules.
  task automatic do_run(input string tag, input int n, input bit hold, input int go_len);
    int go_edge;
    clear_obs();
    hold_ack = hold;
    NumProgs = n[1:0];
    Go = 1'b1;
    go_edge = cyc + 1;
    for (int k = 0; k < go_len; k++) tick();
    Go = 1'b0;
    wait_done(tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_rst_len"}, rst_hi, RSC);
    check({tag, "_rst_lat"}, first_rst, go_edge);
    check({tag, "_start_len"}, start_hi, SC * n);
    if (n > 0) check({tag, "_start_lat"}, first_start, go_edge + RSC);
    check({tag, "_nlogs"}, log_idx.size(), n);
    for (int i = 0; i < n && i < log_idx.size(); i++) begin
      check({tag, "_log_idx"}, log_idx[i], i);
      check({tag, "_log_cyc"}, log_cyc[i], hold ? 1 : dly[i]);
    end
    check({tag, "_timedout"}, TimedOut, 0);
    tick();
    tick();
    check({tag, "_done_stays"}, Done, 1);
    check({tag, "_no_extra_log"}, log_idx.size(), n);
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; NumProgs = 2'd0; DutAck = 1'b0;
    hold_ack = 0; started = 0; running = 0; rc = 0;
    dly = '{0, 0, 0, 0};
    clear_obs();
    repeat (3) tick();
    check("reset_outs", {DutReset, DutStart, ProgIdx, LastCycles, LogValid, Busy, Done, TimedOut}, 0);
    Reset = 1'b0;
    tick();
    check("idle_busy", Busy, 0);
    check("idle_done", Done, 0);

    dly = '{10, 0, 0, 0};
    do_run("one_prog", 1, 0, 1);
    dly = '{5, 7, 9, 0};
    do_run("three_prog", 3, 0, 1);
    do_run("stale_ack", 2, 1, 1);
    hold_ack = 0;
    do_run("zero_prog", 0, 0, 1);
    dly = '{3, 4, 0, 0};
    do_run("go_held", 2, 0, 3);

    for (int r = 0; r < 8; r++) begin
      int n;
      bit h;
      n = $urandom_range(0, 3);
      h = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 15);
      do_run("rand", n, h, $urandom_range(1, 2));
      hold_ack = 0;
    end

    // Go during RUN is ignored; Reset mid-RUN clears everything on the next edge.
    dly = '{40, 0, 0, 0};
    clear_obs();
    NumProgs = 2'd1;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    for (int k = 0; k < 200 && !(running && rc >= 5); k++) tick();
    check("midrun_reached", running, 1);
    Go = 1'b1;
    tick();
    Go = 1'b0;
    tick();
    check("midrun_go_busy", Busy, 1);
    check("midrun_go_no_rst", DutReset, 0);
    check("midrun_rst_len", rst_hi, RSC);
    Reset = 1'b1;
    tick();
    check("midrun_reset_outs", {DutReset, DutStart, ProgIdx, LastCycles, LogValid, Busy, Done, TimedOut}, 0);
    Reset = 1'b0;
    tick();
    check("midrun_idle", {Busy, Done}, 0);

`ifdef RUN_SEQ_TIMEOUT_EN
    dly = '{0, 0, 0, 0};
    clear_obs();
    NumProgs = 2'd2;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    wait_done("tmo");
    check("tmo_flag", TimedOut, 1);
    check("tmo_last", LastCycles, TMO);
    check("tmo_nlogs", log_idx.size(), 1);
    if (log_idx.size() > 0) check("tmo_log_cyc", log_cyc[0], TMO);
    check("tmo_start_len", start_hi, SC);
    Go = 1'b1;
    tick();
    Go = 1'b0;
    check("tmo_clear", TimedOut, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
